game_flow_ctrl: RTL and testbench

//  Parametrised top-level game sequencer for the brick-breaker datapath. Owns the game FSM.

---
 rtl/game_pkg.sv | 18 +
 rtl/frame_tick_gen.sv | 38 +++
 rtl/game_flow_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and default constants for the brick-breaker game sequencer.
package game_pkg;

    // Top-level game phases owned by game_flow_ctrl
    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        LOSS,
        CLEAR,
        OVER
    } game_state_t;

    // 60 Hz frame rate from a 50 MHz system clock
    localparam int FRAME_DIV_DEF = 833333;
    localparam int LIFE_W_DEF    = 3;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame divider: counts clock cycles and flags the last cycle of each frame.
// The tick is combinational so the owner can register it together with its
// own state and keep every externally visible output registered.
module frame_tick_gen
    import game_pkg::*;
#(
    parameter int FRAME_DIV = FRAME_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(FRAME_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = en && !clr && (cnt_q == CNT_LAST);

    // Cycle counter: cleared on request, wraps at FRAME_DIV-1 while enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer for the brick-breaker datapath: owns the game FSM, the frame
// strobe, serve/loss/stage-clear control pulses and the display req/ack handshake.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int LIFE_W       = LIFE_W_DEF,
    parameter int NUM_STAGES   = 4,
    parameter int STAGE_W      = 2,
    parameter int FRAME_DIV    = FRAME_DIV_DEF,
    parameter int SERVE_FRAMES = 180,
    parameter int HOLD_FRAMES  = 120
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_down_detected,
    input  logic               i_up_detected,
    input  logic [LIFE_W-1:0]  i_life_count,
    input  logic               i_collision_life_loss,
    input  logic               i_brick_next_stage,
    input  logic               i_disp_ctrl_req,
    output logic               o_cal_frame,
    output logic               o_game_start,
    output logic               o_disp_ctrl_startgame,
    output logic               o_platform_initial_grab,
    output logic               o_ball_grab,
    output logic               o_ball_shoot,
    output logic               o_gadget_use,
    output logic               o_gadget_reset,
    output logic               o_score_life_loss,
    output logic               o_brick_load_stage,
    output logic [STAGE_W-1:0] o_stage,
    output logic               o_disp_ctrl_endgame,
    output logic               o_win,
    output logic               o_disp_ctrl_ack
);

    localparam int FRAME_MAX = (SERVE_FRAMES > HOLD_FRAMES) ? SERVE_FRAMES : HOLD_FRAMES;
    localparam int FCNT_W    = $clog2(FRAME_MAX + 1);
    localparam logic [FCNT_W-1:0]  FCNT_MAX   = FCNT_W'(FRAME_MAX);
    localparam logic [FCNT_W-1:0]  SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
    localparam logic [FCNT_W-1:0]  HOLD_CNT   = FCNT_W'(HOLD_FRAMES);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);

    game_state_t        state_q;
    logic [FCNT_W-1:0]  frameCnt_q;
    logic [STAGE_W-1:0] stage_q;
    logic               reqArmed_q;
    logic               calFrame_q, gameStart_q, platGrab_q, ballGrab_q, ballShoot_q;
    logic               gadgetUse_q, gadgetReset_q, scoreLoss_q, loadStage_q;
    logic               endgame_q, win_q, ack_q;

    logic tickEn;
    logic frameTick;
    logic serveDone;
    logic holdDone;
    logic ackOk;

    // Frames are only timed in the phases that need them; every other phase
    // holds the divider at zero so SERVE and OVER always start a fresh frame.
    assign tickEn    = (state_q == SERVE) || (state_q == PLAY) || (state_q == OVER);
    assign serveDone = frameTick && (frameCnt_q == SERVE_LAST);
    assign holdDone  = (frameCnt_q >= HOLD_CNT);
    assign ackOk     = i_disp_ctrl_req && reqArmed_q;

    frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tickEn),
        .clr   (!tickEn),
        .tick  (frameTick)
    );

    // Game FSM with registered outputs; pulses default low and are raised by the transition that causes them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            frameCnt_q    <= '0;
            stage_q       <= '0;
            reqArmed_q    <= 1'b1;
            calFrame_q    <= 1'b0;
            gameStart_q   <= 1'b0;
            platGrab_q    <= 1'b0;
            ballGrab_q    <= 1'b0;
            ballShoot_q   <= 1'b0;
            gadgetUse_q   <= 1'b0;
            gadgetReset_q <= 1'b0;
            scoreLoss_q   <= 1'b0;
            loadStage_q   <= 1'b0;
            endgame_q     <= 1'b0;
            win_q         <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            gameStart_q   <= 1'b0;
            platGrab_q    <= 1'b0;
            ballShoot_q   <= 1'b0;
            gadgetUse_q   <= 1'b0;
            gadgetReset_q <= 1'b0;
            scoreLoss_q   <= 1'b0;
            loadStage_q   <= 1'b0;
            ack_q         <= 1'b0;
            calFrame_q    <= frameTick && ((state_q == SERVE) || (state_q == PLAY));

            // A dropped request re-arms the acknowledge so each ack needs a fresh req
            if (!i_disp_ctrl_req) begin
                reqArmed_q <= 1'b1;
            end

            if (!tickEn) begin
                frameCnt_q <= '0;
            end else if (frameTick && (frameCnt_q != FCNT_MAX)) begin
                frameCnt_q <= frameCnt_q + FCNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (i_down_detected) begin
                        state_q       <= SERVE;
                        gameStart_q   <= 1'b1;
                        platGrab_q    <= 1'b1;
                        gadgetReset_q <= 1'b1;
                        loadStage_q   <= 1'b1;
                        ballGrab_q    <= 1'b1;
                        stage_q       <= '0;
                        win_q         <= 1'b0;
                    end
                end
                SERVE: begin
                    if (i_down_detected || serveDone) begin
                        state_q     <= PLAY;
                        ballShoot_q <= 1'b1;
                        ballGrab_q  <= 1'b0;
                    end
                end
                PLAY: begin
                    gadgetUse_q <= i_up_detected;
                    if (i_collision_life_loss) begin
                        state_q     <= LOSS;
                        scoreLoss_q <= 1'b1;
                    end else if (i_brick_next_stage) begin
                        state_q <= CLEAR;
                    end
                end
                LOSS: begin
                    gadgetReset_q <= 1'b1;
                    if (i_life_count == '0) begin
                        state_q   <= OVER;
                        endgame_q <= 1'b1;
                    end else begin
                        state_q    <= SERVE;
                        platGrab_q <= 1'b1;
                        ballGrab_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ackOk) begin
                        ack_q      <= 1'b1;
                        reqArmed_q <= 1'b0;
                        if (stage_q == STAGE_LAST) begin
                            state_q   <= OVER;
                            endgame_q <= 1'b1;
                            win_q     <= 1'b1;
                        end else begin
                            state_q       <= SERVE;
                            stage_q       <= stage_q + STAGE_W'(1);
                            loadStage_q   <= 1'b1;
                            platGrab_q    <= 1'b1;
                            gadgetReset_q <= 1'b1;
                            ballGrab_q    <= 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (holdDone && i_down_detected && ackOk) begin
                        state_q    <= IDLE;
                        ack_q      <= 1'b1;
                        reqArmed_q <= 1'b0;
                        endgame_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_cal_frame             = calFrame_q;
    assign o_game_start            = gameStart_q;
    assign o_disp_ctrl_startgame   = gameStart_q;
    assign o_platform_initial_grab = platGrab_q;
    assign o_ball_grab             = ballGrab_q;
    assign o_ball_shoot            = ballShoot_q;
    assign o_gadget_use            = gadgetUse_q;
    assign o_gadget_reset          = gadgetReset_q;
    assign o_score_life_loss       = scoreLoss_q;
    assign o_brick_load_stage      = loadStage_q;
    assign o_stage                 = stage_q;
    assign o_disp_ctrl_endgame     = endgame_q;
    assign o_win                   = win_q;
    assign o_disp_ctrl_ack         = ack_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed testbench for game_flow_ctrl with a short frame and two stages.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       downDet, upDet, lifeLoss, nextStage, dispReq;
    logic [2:0] lifeCount;

    logic       calFrame, gameStart, startGame, platGrab, ballGrab, ballShoot;
    logic       gadgetUse, gadgetReset, scoreLoss, loadStage, endgame, win, ack;
    logic       stage;

    int testsRun  = 0;
    int testsFail = 0;
    int ackCount;
    int loadCount;

    game_flow_ctrl #(
        .LIFE_W       (3),
        .NUM_STAGES   (2),
        .STAGE_W      (1),
        .FRAME_DIV    (4),
        .SERVE_FRAMES (3),
        .HOLD_FRAMES  (2)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .i_down_detected         (downDet),
        .i_up_detected           (upDet),
        .i_life_count            (lifeCount),
        .i_collision_life_loss   (lifeLoss),
        .i_brick_next_stage      (nextStage),
        .i_disp_ctrl_req         (dispReq),
        .o_cal_frame             (calFrame),
        .o_game_start            (gameStart),
        .o_disp_ctrl_startgame   (startGame),
        .o_platform_initial_grab (platGrab),
        .o_ball_grab             (ballGrab),
        .o_ball_shoot            (ballShoot),
        .o_gadget_use            (gadgetUse),
        .o_gadget_reset          (gadgetReset),
        .o_score_life_loss       (scoreLoss),
        .o_brick_load_stage      (loadStage),
        .o_stage                 (stage),
        .o_disp_ctrl_endgame     (endgame),
        .o_win                   (win),
        .o_disp_ctrl_ack         (ack)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    // Safety net so a broken design can never stall the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] allOutputs();
        return {calFrame, gameStart, startGame, platGrab, ballGrab, ballShoot, gadgetUse,
                gadgetReset, scoreLoss, loadStage, stage, endgame, win, ack, 2'b00};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the sampling edge
    task automatic applyStimulus(input logic down, input logic up, input logic loss,
                                 input logic nxt, input logic req);
        downDet   = down;
        upDet     = up;
        lifeLoss  = loss;
        nextStage = nxt;
        dispReq   = req;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic req);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, req);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        lifeCount = 3'd2;
        idleCycles(2, 1'b0);
        checkOutput("reset_outputs", 32'(allOutputs()), 32'd0);
        rst_n = 1'b1;
        idleCycles(1, 1'b0);
        checkOutput("idle_outputs", 32'(allOutputs()), 32'd0);

        // Game start and frame strobe cadence
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("start_game_start", 32'(gameStart), 32'd1);
        checkOutput("start_disp_start", 32'(startGame), 32'd1);
        checkOutput("start_load_stage", 32'(loadStage), 32'd1);
        checkOutput("start_plat_grab", 32'(platGrab), 32'd1);
        checkOutput("start_gadget_reset", 32'(gadgetReset), 32'd1);
        checkOutput("start_ball_grab", 32'(ballGrab), 32'd1);
        checkOutput("start_stage", 32'(stage), 32'd0);
        idleCycles(1, 1'b0);
        checkOutput("start_pulse_ends", 32'(gameStart), 32'd0);
        idleCycles(2, 1'b0);
        checkOutput("frame_not_yet", 32'(calFrame), 32'd0);
        idleCycles(1, 1'b0);
        checkOutput("frame_tick_1", 32'(calFrame), 32'd1);
        idleCycles(1, 1'b0);
        checkOutput("frame_tick_low", 32'(calFrame), 32'd0);
        idleCycles(3, 1'b0);
        checkOutput("frame_tick_2", 32'(calFrame), 32'd1);

        // Auto-serve after three frames
        idleCycles(3, 1'b0);
        checkOutput("serve_no_shoot_yet", 32'(ballShoot), 32'd0);
        checkOutput("serve_grab_held", 32'(ballGrab), 32'd1);
        idleCycles(1, 1'b0);
        checkOutput("auto_shoot", 32'(ballShoot), 32'd1);
        checkOutput("auto_shoot_grab_off", 32'(ballGrab), 32'd0);
        checkOutput("auto_shoot_frame", 32'(calFrame), 32'd1);

        // Life loss with lives left returns to SERVE
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("loss_score_pulse", 32'(scoreLoss), 32'd1);
        idleCycles(1, 1'b0);
        checkOutput("loss_plat_grab", 32'(platGrab), 32'd1);
        checkOutput("loss_ball_grab", 32'(ballGrab), 32'd1);
        checkOutput("loss_not_over", 32'(endgame), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("manual_shoot", 32'(ballShoot), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("gadget_use", 32'(gadgetUse), 32'd1);

        // Last life lost ends the game
        lifeCount = 3'd0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("last_loss_score", 32'(scoreLoss), 32'd1);
        idleCycles(1, 1'b0);
        checkOutput("over_endgame", 32'(endgame), 32'd1);
        checkOutput("over_no_grab", 32'(platGrab), 32'd0);
        checkOutput("over_lost_win", 32'(win), 32'd0);
        idleCycles(9, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("restart_ack", 32'(ack), 32'd1);
        checkOutput("restart_endgame_off", 32'(endgame), 32'd0);
        idleCycles(1, 1'b0);

        // Simultaneous loss and clear resolves to loss
        lifeCount = 3'd2;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("both_score_loss", 32'(scoreLoss), 32'd1);
        idleCycles(1, 1'b0);
        checkOutput("both_stage_same", 32'(stage), 32'd0);
        checkOutput("both_no_load", 32'(loadStage), 32'd0);
        checkOutput("both_back_serve", 32'(ballGrab), 32'd1);

        // Stage clear with request held several cycles yields one ack
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idleCycles(1, 1'b0);
        checkOutput("clear_waits_req", 32'(ack), 32'd0);
        ackCount  = 0;
        loadCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            ackCount  += int'(ack);
            loadCount += int'(loadStage);
        end
        checkOutput("clear_ack_count", 32'(ackCount), 32'd1);
        checkOutput("clear_load_count", 32'(loadCount), 32'd1);
        checkOutput("clear_stage_1", 32'(stage), 32'd1);
        idleCycles(1, 1'b0);

        // Clearing the last stage wins the game
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idleCycles(1, 1'b0);
        checkOutput("final_clear_wait", 32'(ack), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("win_ack", 32'(ack), 32'd1);
        checkOutput("win_flag", 32'(win), 32'd1);
        checkOutput("win_endgame", 32'(endgame), 32'd1);
        checkOutput("win_stage_held", 32'(stage), 32'd1);

        // Hold time in OVER: early restart dropped, later one accepted
        idleCycles(5, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("early_restart_ack", 32'(ack), 32'd0);
        checkOutput("early_restart_over", 32'(endgame), 32'd1);
        idleCycles(2, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("hold_restart_ack", 32'(ack), 32'd1);
        checkOutput("hold_restart_idle", 32'(endgame), 32'd0);
        idleCycles(1, 1'b1);
        checkOutput("hold_ack_pulse", 32'(ack), 32'd0);
        idleCycles(1, 1'b0);

        // Reset mid-play aborts without final pulses
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_play", 32'(ballShoot), 32'd1);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("midgame_reset", 32'(allOutputs()), 32'd0);
        rst_n = 1'b1;
        idleCycles(1, 1'b0);
        checkOutput("post_reset_quiet", 32'(allOutputs()), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_reset_idle", 32'(gameStart), 32'd1);
        checkOutput("post_reset_stage", 32'(stage), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
